// File: rtl/fpga_issue_sched.sv
// fpga_issue_sched: issue scheduler and entry allocator for the FPGA-unit
// reservation station.
//
// Each cycle up to three ready RS entries are granted, one each to the
// functional units C1, C2 and E1, scanning circularly from a round-robin
// pointer. Per-unit latency counters block re-issue until the unit is free.
// A branch mispredict kills in-flight unit ops whose spectag is in the kill
// mask. Free entry addresses for dispatch are produced combinationally.
//
// Optional feature macro: FPGA_SCHED_E1_EN. When it is undefined, E1 is
// never granted, its state stays zero and its outputs are tied low.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   busyvec, ready, ent_spectag    RS entry status / per-entry spectag
//   req_num                        entries dispatch wants (3 counts as 2)
//   allocatable, allocent1/2       free-entry information for dispatch
//   stall_C1/C2/E1                 unit back-pressure
//   clearbusy_*, issueaddr_*       combinational grant per unit
//   prmiss, prsuccess, prtag,
//   specfixtag                     branch resolution
//   kill_C1/C2/E1                  registered one-cycle kill pulses
//   unit_busy                      {E1,C2,C1} latency counter non-zero

`ifndef FPGA_ENT_NUM
`define FPGA_ENT_NUM 4
`endif
`ifndef FPGA_ENT_SEL
`define FPGA_ENT_SEL 2
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

module fpga_issue_sched #(
  parameter int ENT_NUM     = `FPGA_ENT_NUM,
  parameter int ENT_SEL     = `FPGA_ENT_SEL,
  parameter int SPECTAG_LEN = `SPECTAG_LEN,
  parameter int UNIT_LAT    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ENT_NUM-1:0]             busyvec,
  input  logic [ENT_NUM-1:0]             ready,
  input  logic [ENT_NUM*SPECTAG_LEN-1:0] ent_spectag,
  input  logic [1:0]                     req_num,
  output logic                           allocatable,
  output logic [ENT_SEL-1:0]             allocent1,
  output logic [ENT_SEL-1:0]             allocent2,
  input  logic                           stall_C1,
  input  logic                           stall_C2,
  input  logic                           stall_E1,
  output logic                           clearbusy_C1,
  output logic                           clearbusy_C2,
  output logic                           clearbusy_E1,
  output logic [ENT_SEL-1:0]             issueaddr_C1,
  output logic [ENT_SEL-1:0]             issueaddr_C2,
  output logic [ENT_SEL-1:0]             issueaddr_E1,
  input  logic                           prmiss,
  input  logic                           prsuccess,
  input  logic [SPECTAG_LEN-1:0]         prtag,
  input  logic [SPECTAG_LEN-1:0]         specfixtag,
  output logic                           kill_C1,
  output logic                           kill_C2,
  output logic                           kill_E1,
  output logic [2:0]                     unit_busy
);

  localparam int NU = 3;  // unit index: 0=C1, 1=C2, 2=E1
`ifdef FPGA_SCHED_E1_EN
  localparam logic [NU-1:0] UNIT_EN = 3'b111;
`else
  localparam logic [NU-1:0] UNIT_EN = 3'b011;
`endif

  logic [NU-1:0][3:0]             cnt_q, cnt_d;
  logic [NU-1:0][SPECTAG_LEN-1:0] tag_q, tag_d;
  logic [NU-1:0]                  kill_q, kill_d;
  logic [ENT_SEL-1:0]             rr_q, rr_d;

  logic [ENT_NUM-1:0][SPECTAG_LEN-1:0] st_arr;
  logic [NU-1:0]                  stall, avail, gnt;
  logic [NU-1:0][ENT_SEL-1:0]     gaddr;
  logic [NU-1:0][SPECTAG_LEN-1:0] gtag;
  logic [ENT_NUM-1:0]             taken;
  logic [ENT_SEL:0]               sum;
  logic [ENT_SEL-1:0]             idx, last_idx;
  logic                           any_gnt;

  logic [4:0]                     nfree;
  logic [1:0]                     req_eff;
  logic                           f1, f2;

  assign st_arr = ent_spectag;
  assign stall  = {stall_E1, stall_C2, stall_C1};

  // ---------------- allocation ----------------
  always_comb begin
    allocent1 = '0;
    allocent2 = '0;
    nfree     = '0;
    f1        = 1'b0;
    f2        = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!busyvec[i]) begin
        nfree = nfree + 5'd1;
        if (!f1) begin
          allocent1 = ENT_SEL'(i);
          f1        = 1'b1;
        end else if (!f2) begin
          allocent2 = ENT_SEL'(i);
          f2        = 1'b1;
        end
      end
    end
  end

  assign req_eff     = (req_num == 2'd3) ? 2'd2 : req_num;
  assign allocatable = (nfree >= {3'b000, req_eff});

  // ---------------- grant ----------------
  always_comb begin
    for (int u = 0; u < NU; u++)
      avail[u] = UNIT_EN[u] && (cnt_q[u] == 4'd0) && !stall[u] && !prmiss && !reset;
  end

  // Units are served in order; each takes the first untaken ready entry in
  // circular order from rr_q. Because units scan the same order, the last
  // grant made is always the furthest one around the ring.
  always_comb begin
    taken    = '0;
    gnt      = '0;
    gaddr    = '0;
    gtag     = '0;
    sum      = '0;
    idx      = '0;
    last_idx = '0;
    any_gnt  = 1'b0;
    for (int u = 0; u < NU; u++) begin
      for (int k = 0; k < ENT_NUM; k++) begin
        sum = {1'b0, rr_q} + (ENT_SEL+1)'(k);
        if (sum >= (ENT_SEL+1)'(ENT_NUM)) sum = sum - (ENT_SEL+1)'(ENT_NUM);
        idx = sum[ENT_SEL-1:0];
        if (avail[u] && !gnt[u] && ready[idx] && !taken[idx]) begin
          gnt[u]     = 1'b1;
          gaddr[u]   = idx;
          gtag[u]    = st_arr[idx];
          taken[idx] = 1'b1;
          last_idx   = idx;
          any_gnt    = 1'b1;
        end
      end
    end
  end

  assign clearbusy_C1 = gnt[0];
  assign clearbusy_C2 = gnt[1];
  assign clearbusy_E1 = gnt[2];
  assign issueaddr_C1 = gaddr[0];
  assign issueaddr_C2 = gaddr[1];
  assign issueaddr_E1 = gaddr[2];
  assign kill_C1      = kill_q[0];
  assign kill_C2      = kill_q[1];
  assign kill_E1      = kill_q[2];

  always_comb begin
    for (int u = 0; u < NU; u++) unit_busy[u] = (cnt_q[u] != 4'd0);
  end

  // ---------------- next state ----------------
  always_comb begin
    cnt_d  = cnt_q;
    tag_d  = tag_q;
    kill_d = '0;
    for (int u = 0; u < NU; u++) begin
      if (!UNIT_EN[u]) begin
        cnt_d[u] = '0;
        tag_d[u] = '0;
      end else if (prmiss) begin
        if (((tag_q[u] & specfixtag) != '0) && (cnt_q[u] != 4'd0)) begin
          cnt_d[u]  = '0;
          tag_d[u]  = '0;
          kill_d[u] = 1'b1;
        end else if (cnt_q[u] != 4'd0) begin
          cnt_d[u] = cnt_q[u] - 4'd1;
        end
      end else if (gnt[u]) begin
        cnt_d[u] = 4'(UNIT_LAT - 1);
        // A branch resolving correctly in the grant cycle must not leave its
        // tag on the new op.
        tag_d[u] = (prsuccess && (gtag[u] == prtag)) ? '0 : gtag[u];
      end else begin
        if (cnt_q[u] != 4'd0) cnt_d[u] = cnt_q[u] - 4'd1;
        if (prsuccess && (tag_q[u] == prtag)) tag_d[u] = '0;
      end
    end

    rr_d = rr_q;
    if (prmiss)
      rr_d = '0;
    else if (any_gnt)
      rr_d = (last_idx == ENT_SEL'(ENT_NUM - 1)) ? '0 : last_idx + ENT_SEL'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tag_q  <= '0;
      kill_q <= '0;
      rr_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
      kill_q <= kill_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_fpga_issue_sched.sv
// Testbench for fpga_issue_sched: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model (per-unit "free at cycle" times, a circular ready queue).
module tb_fpga_issue_sched;
  localparam int N = 4, SEL = 2, TL = 5, LAT = 4;
`ifdef FPGA_SCHED_E1_EN
  localparam bit E1 = 1'b1;
`else
  localparam bit E1 = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         busyvec, ready;
  logic [N-1:0][TL-1:0] st;
  logic [1:0]           req_num;
  logic                 allocatable;
  logic [SEL-1:0]       allocent1, allocent2;
  logic                 stall_C1, stall_C2, stall_E1;
  logic                 clearbusy_C1, clearbusy_C2, clearbusy_E1;
  logic [SEL-1:0]       issueaddr_C1, issueaddr_C2, issueaddr_E1;
  logic                 prmiss, prsuccess;
  logic [TL-1:0]        prtag, specfixtag;
  logic                 kill_C1, kill_C2, kill_E1;
  logic [2:0]           unit_busy;

  fpga_issue_sched #(.ENT_NUM(N), .ENT_SEL(SEL), .SPECTAG_LEN(TL), .UNIT_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .busyvec(busyvec), .ready(ready), .ent_spectag(st),
    .req_num(req_num), .allocatable(allocatable), .allocent1(allocent1), .allocent2(allocent2),
    .stall_C1(stall_C1), .stall_C2(stall_C2), .stall_E1(stall_E1),
    .clearbusy_C1(clearbusy_C1), .clearbusy_C2(clearbusy_C2), .clearbusy_E1(clearbusy_E1),
    .issueaddr_C1(issueaddr_C1), .issueaddr_C2(issueaddr_C2), .issueaddr_E1(issueaddr_E1),
    .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag), .specfixtag(specfixtag),
    .kill_C1(kill_C1), .kill_C2(kill_C2), .kill_E1(kill_E1), .unit_busy(unit_busy)
  );

  always #5 clk = ~clk;

  // model state
  int      free_at [3];   // first cycle at which the unit may be granted again
  logic [TL-1:0] mtag [3];
  bit      mkill [3];
  int      mrr;
  int      cyc;
  int      n_vec, n_err;

  task automatic chk(string nm, int act, int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin free_at[u] = 0; mtag[u] = '0; mkill[u] = 0; end
    mrr = 0;
  endtask

  task automatic set_idle();
    busyvec = '0; ready = '0; req_num = '0;
    stall_C1 = 0; stall_C2 = 0; stall_E1 = 0;
    prmiss = 0; prsuccess = 0; prtag = '0; specfixtag = '0;
  endtask

  // Called at a negedge with inputs applied: compare, clock, update model.
  task automatic cycle();
    int q[$];
    bit eg[3];
    int ea[3];
    bit av, any, en;
    int last;
    logic [2:0] cb, kl, stl;
    int ia[3];
    #1;
    q = {};
    for (int i = 0; i < N; i++) if (!busyvec[i]) q.push_back(i);
    chk("allocent1", allocent1, q.size() > 0 ? q[0] : 0);
    chk("allocent2", allocent2, q.size() > 1 ? q[1] : 0);
    chk("allocatable", allocatable, int'(q.size() >= ((req_num == 2'd3) ? 2 : int'(req_num))));

    q = {};
    for (int k = 0; k < N; k++) if (ready[(mrr + k) % N]) q.push_back((mrr + k) % N);
    stl = {stall_E1, stall_C2, stall_C1};
    cb  = {clearbusy_E1, clearbusy_C2, clearbusy_C1};
    kl  = {kill_E1, kill_C2, kill_C1};
    ia[0] = issueaddr_C1; ia[1] = issueaddr_C2; ia[2] = issueaddr_E1;
    any = 0; last = 0;
    for (int u = 0; u < 3; u++) begin
      en = (u < 2) || E1;
      av = en && (cyc >= free_at[u]) && !stl[u] && !prmiss && !reset;
      eg[u] = 0; ea[u] = 0;
      if (av && q.size() > 0) begin
        eg[u] = 1; ea[u] = q.pop_front(); any = 1; last = ea[u];
      end
      chk($sformatf("clearbusy[%0d]", u), cb[u], eg[u]);
      chk($sformatf("issueaddr[%0d]", u), ia[u], ea[u]);
      chk($sformatf("kill[%0d]", u), kl[u], (reset || !en) ? 0 : mkill[u]);
      chk($sformatf("unit_busy[%0d]", u), unit_busy[u], (reset || !en) ? 0 : int'(cyc < free_at[u]));
    end
    n_vec++;

    @(posedge clk);
    if (reset) model_reset();
    else begin
      for (int u = 0; u < 3; u++) begin
        mkill[u] = 0;
        if ((u < 2) || E1) begin
          if (prmiss) begin
            if (((mtag[u] & specfixtag) != '0) && (cyc < free_at[u])) begin
              free_at[u] = cyc + 1; mtag[u] = '0; mkill[u] = 1;
            end
          end else if (eg[u]) begin
            free_at[u] = cyc + LAT;
            mtag[u] = (prsuccess && st[ea[u]] == prtag) ? '0 : st[ea[u]];
          end else if (prsuccess && mtag[u] == prtag) mtag[u] = '0;
        end
      end
      if (prmiss) mrr = 0;
      else if (any) mrr = (last + 1) % N;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    set_idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [TL-1:0] rand_tag();
    int r;
    r = $urandom_range(0, TL);
    return (r == TL) ? '0 : TL'(1 << r);
  endfunction

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    model_reset();
    set_idle();
    st = '0;
    reset = 0;
    #1 reset = 1;
    busyvec = 4'hF; ready = 4'hF;
    @(negedge clk);

    // reset: nothing granted, nothing busy
    #1 chk("rst_clearbusy", {29'd0, clearbusy_E1, clearbusy_C2, clearbusy_C1}, 0);
    chk("rst_unit_busy", unit_busy, 0);
    cycle();

    // first cycle after reset: C1=0, C2=1, E1=2
    reset = 0;
    #1 chk("post_rst_C1", issueaddr_C1, 0);
    chk("post_rst_C1_cb", clearbusy_C1, 1);
    chk("post_rst_C2", issueaddr_C2, 1);
    chk("post_rst_C2_cb", clearbusy_C2, 1);
    chk("post_rst_E1_cb", clearbusy_E1, E1 ? 1 : 0);
    chk("post_rst_E1", issueaddr_E1, E1 ? 2 : 0);
    cycle();
    idle(4);

    // round robin + occupancy: only C1 free, ready 1001
    set_idle(); ready = 4'b1001; busyvec = 4'b1001; stall_C2 = 1; stall_E1 = 1;
    #1 chk("rr_C1_cb", clearbusy_C1, 1);
    chk("rr_C1_addr", issueaddr_C1, 3);
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1 chk("C1_occupied_cb", clearbusy_C1, 0);
      chk("C1_occupied_busy", unit_busy[0], 1);
      cycle();
    end
    #1 chk("C1_regrant_cb", clearbusy_C1, 1);
    chk("C1_regrant_addr", issueaddr_C1, 0);
    cycle();
    idle(4);

    // stall and allocation
    set_idle(); stall_C1 = 1; ready = 4'b0100; busyvec = 4'b0100;
    #1 chk("stall_C1_cb", clearbusy_C1, 0);
    chk("stall_C2_cb", clearbusy_C2, 1);
    chk("stall_C2_addr", issueaddr_C2, 2);
    cycle();
    set_idle(); busyvec = 4'b1011; req_num = 2;
    #1 chk("alloc1_1011", allocent1, 2);
    chk("allocatable_1011", allocatable, 0);
    cycle();
    set_idle(); busyvec = 4'b1010; req_num = 3;
    #1 chk("alloc1_1010", allocent1, 0);
    chk("alloc2_1010", allocent2, 2);
    chk("allocatable_1010", allocatable, 1);
    cycle();
    idle(4);

    // mispredict kill
    set_idle(); ready = 4'b0001; busyvec = 4'b0001; st[0] = 5'b00010;
    #1 chk("kill_issue_cb", clearbusy_C1, 1);
    chk("kill_issue_addr", issueaddr_C1, 0);
    cycle();
    idle(1);
    prmiss = 1; specfixtag = 5'b00110;
    #1 chk("kill_pre", kill_C1, 0);
    chk("miss_no_grant", clearbusy_C1, 0);
    cycle();
    set_idle();
    #1 chk("kill_C1_pulse", kill_C1, 1);
    chk("kill_C1_cnt0", unit_busy[0], 0);
    cycle();
    #1 chk("kill_C1_oneshot", kill_C1, 0);
    cycle();
    // non-matching kill mask
    ready = 4'b0001; busyvec = 4'b0001;
    cycle();
    idle(1);
    prmiss = 1; specfixtag = 5'b01000;
    cycle();
    set_idle();
    #1 chk("nokill_C1", kill_C1, 0);
    chk("nokill_C1_busy", unit_busy[0], 1);
    cycle();
    idle(4);

    // prsuccess clears tag, later prmiss does not kill
    ready = 4'b0001; busyvec = 4'b0001;
    cycle();
    set_idle(); prsuccess = 1; prtag = 5'b00010;
    cycle();
    set_idle(); prmiss = 1; specfixtag = 5'b00010;
    cycle();
    set_idle();
    #1 chk("prsucc_nokill", kill_C1, 0);
    chk("prsucc_busy", unit_busy[0], 1);
    cycle();
    idle(4);

    // reset mid-operation
    ready = 4'hF; busyvec = 4'hF;
    cycle();
    set_idle();
    #2 reset = 1;
    #1 chk("midrst_busy", unit_busy, 0);
    cycle();
    reset = 0; ready = 4'hF; busyvec = 4'hF;
    #1 chk("midrst_avail_C1", clearbusy_C1, 1);
    cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      busyvec    = N'($urandom);
      ready      = N'($urandom) & busyvec;
      for (int i = 0; i < N; i++) st[i] = rand_tag();
      req_num    = 2'($urandom);
      stall_C1   = ($urandom % 4 == 0);
      stall_C2   = ($urandom % 4 == 0);
      stall_E1   = ($urandom % 4 == 0);
      prmiss     = ($urandom % 10 == 0);
      prsuccess  = ($urandom % 5 == 0);
      prtag      = rand_tag();
      specfixtag = TL'($urandom);
      reset      = ($urandom % 150 == 0);
      cycle();
    end
    reset = 0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpga_issue_sched.md
# fpga_issue_sched

Issue scheduler and entry allocator for the FPGA-unit reservation station. Each cycle it grants up to three ready RS entries, one each to the FPGA functional units C1, C2 and E1, and drives the RS `clearbusy_*`/`issueaddr_*` inputs. It tracks per-unit occupancy with latency counters, kills in-flight operations on branch mispredict, and supplies free entry addresses to dispatch. It sits between the RS `busyvec`/`ready` outputs and the dispatch/issue control.

## Interface
- `ENT_NUM`, default `FPGA_ENT_NUM`: RS entry count, 2..16.
- `ENT_SEL`, default `FPGA_ENT_SEL`: entry address width, equal to clog2(ENT_NUM).
- `SPECTAG_LEN`, default `SPECTAG_LEN`: speculative tag width (one-hot).
- `UNIT_LAT`, default 4: cycles a unit is occupied per op, 1..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `busyvec`  in  ENT_NUM  RS entry occupied
- `ready`  in  ENT_NUM  RS entry operands resolved and busy
- `ent_spectag`  in  ENT_NUM*SPECTAG_LEN  per-entry spectag, entry i at bits [i*SPECTAG_LEN +: SPECTAG_LEN]
- `req_num`  in  2  entries dispatch wants this cycle (0..2; 3 is treated as 2)
- `allocatable`  out  1  free entry count ≥ req_num
- `allocent1`, `allocent2`  out  ENT_SEL  lowest and second-lowest free entry
- `stall_C1`, `stall_C2`, `stall_E1`  in  1  unit back-pressure
- `clearbusy_C1`, `clearbusy_C2`, `clearbusy_E1`  out  1  grant this cycle
- `issueaddr_C1`, `issueaddr_C2`, `issueaddr_E1`  out  ENT_SEL  granted entry
- `prmiss`, `prsuccess`  in  1  branch resolution
- `prtag`, `specfixtag`  in  SPECTAG_LEN  resolved tag / kill mask
- `kill_C1`, `kill_C2`, `kill_E1`  out  1  registered kill pulse to unit
- `unit_busy`  out  3  {E1,C2,C1} counter ≠ 0

## Operation
- **Allocation (combinational):**
  - `allocent1` is the lowest index with `busyvec`=0; `allocent2` is the next one.
  - When no free entry exists, both outputs are 0.
  - `allocatable` = (popcount(~busyvec) ≥ req_num).
- **Per-unit state:**
  - `cnt_X`, 4 bits.
  - `tag_X`, SPECTAG_LEN bits.
  - Unit X is available when `cnt_X`==0, `stall_X`=0 and `prmiss`=0.
- **Grant (combinational from registers and inputs):**
  - Units are served in fixed order C1, C2, E1.
  - Each available unit takes the first `ready` entry, scanning circularly from `rr_ptr`, that has not already been taken by an earlier unit this cycle.
  - No ready candidate means no grant.
  - When `clearbusy_X`=0, `issueaddr_X` = 0.
- **On grant to X:**
  - `cnt_X` ← UNIT_LAT-1.
  - `tag_X` ← `ent_spectag` of the granted entry.
- **Counter behaviour:** when `cnt_X`≠0 it decrements by 1 each cycle, independent of stall.
- **Round-robin pointer:** when any grant occurs, `rr_ptr` ← (highest-circular-position granted entry + 1) mod ENT_NUM. Otherwise it holds.
- **prmiss:**
  - No grants that cycle.
  - For each X with (`tag_X` & `specfixtag`)≠0 and `cnt_X`≠0: `cnt_X` ← 0, `tag_X` ← 0, `kill_X`=1 in the next cycle.
  - `rr_ptr` ← 0.
- **prsuccess (no prmiss):** every `tag_X` equal to `prtag` ← 0. Grants proceed normally.
- **Unit kill tracking:** a killed entry still in the RS is cleared by the RS itself; the scheduler only tracks units.

## Timing
- All grant outputs are combinational in cycle t.
- The RS clears `busy` at edge t+1; the scheduler does not re-grant the same entry in the grant cycle.
- With UNIT_LAT=L, unit X can be granted again at cycle t+L at the earliest. L=1 allows back-to-back grants.
- `kill_X` is a one-cycle pulse registered at the edge ending the `prmiss` cycle.
- Reset values:
  - `cnt_*`=0, `tag_*`=0, `rr_ptr`=0, `kill_*`=0, `unit_busy`=0.
  - Grant outputs are 0 while reset is asserted.
- **Reset mid-operation:** all counters clear asynchronously; units are available the first cycle after deassertion.
- **Simultaneous grant and prsuccess:** `tag_X` is loaded with the entry's spectag, masked by ~`prtag` when it equals `prtag`.
- **Stall while `cnt_X`≠0:** the counter still decrements; stall blocks only new grants.

## Configuration
- Macro `FPGA_SCHED_E1_EN`.
- **Defined:** unit E1 is scheduled as described.
- **Undefined:**
  - E1 logic is removed.
  - `clearbusy_E1`=0, `issueaddr_E1`=0, `kill_E1`=0 and `unit_busy[2]`=0.
  - `stall_E1` is ignored.
  - Only C1 and C2 are granted.

## Test plan
All scenarios use ENT_NUM=4, UNIT_LAT=4, SPECTAG_LEN=5, with `FPGA_SCHED_E1_EN` defined unless stated otherwise.

- **Reset:** assert reset with `ready`=4'b1111 → all `clearbusy_*`=0, `unit_busy`=0. Deassert → C1=0, C2=1, E1=2 granted in the same cycle; `rr_ptr` becomes 3.
- **Round-robin and occupancy:** `rr_ptr`=3, `ready`=4'b1001, only C1 free → C1 gets entry 3 and `rr_ptr`=0. C1 is re-grantable exactly 4 cycles later.
- **Stall and allocation:** `stall_C1`=1, `ready`=4'b0100 → C2 gets entry 2 and C1 has no grant. Separately, `busyvec`=4'b1011, `req_num`=2 → `allocent1`=2, `allocatable`=0.
- **Mispredict kill:** issue C1 with spectag 5'b00010, then `prmiss` with `specfixtag`=5'b00110 at cnt=2 → `kill_C1`=1 for one cycle, `cnt_C1`=0. `prmiss` with `specfixtag`=5'b01000 → no kill.
- **prsuccess then prmiss:** `prsuccess` with `prtag`=5'b00010 clears `tag_C1`. A later `prmiss` with `specfixtag`=5'b00010 → no `kill_C1`, and the counter continues.
- **E1 compiled out:** `FPGA_SCHED_E1_EN` undefined, `ready`=4'b0111 → grants go to 0 and 1 only; `clearbusy_E1` stays 0 for the whole run.
